// File: rtl/mrd_fsm_ctrl_if.sv
// Sequencer bus: sink handshake, pass-end pulses, config in,
// and state / stage / status out. master = driver, slave = ctrl.
interface mrd_fsm_ctrl_if;
  logic [11:0] cfg_dftpts;
  logic [2:0]  cfg_nf;
  logic        in_valid;
  logic        in_sop;
  logic        in_eop;
  logic        rd_end;
  logic        wr_end;
  logic        source_end;
  logic        sink_ready;
  logic [2:0]  fsm;
  logic [2:0]  fsm_r;
  logic [2:0]  cnt_stage;
  logic [2:0]  num_factors;
  logic [11:0] dftpts;
  logic        frame_err;
  logic        timeout;

  modport master (
    output cfg_dftpts, cfg_nf,
    output in_valid, in_sop, in_eop,
    output rd_end, wr_end, source_end,
    input  sink_ready, fsm, fsm_r,
    input  cnt_stage, num_factors, dftpts,
    input  frame_err, timeout
  );

  modport slave (
    input  cfg_dftpts, cfg_nf,
    input  in_valid, in_sop, in_eop,
    input  rd_end, wr_end, source_end,
    output sink_ready, fsm, fsm_r,
    output cnt_stage, num_factors, dftpts,
    output frame_err, timeout
  );
endinterface

// File: rtl/mrd_fsm_ctrl.sv
// Mixed-radix DFT frame sequencer: sink, per-factor read passes,
// source. Ports: clk, rst (sync, high), bus (mrd_fsm_ctrl_if.slave).
module mrd_fsm_ctrl #(
  parameter int WAIT_RD = 4,
  parameter int WDOG    = 4095
) (
  input logic           clk,
  input logic           rst,
  mrd_fsm_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SINK = 3'd1,
    S_W2R  = 3'd2,
    S_RD   = 3'd3,
    S_WWE  = 3'd4,
    S_SRC  = 3'd5
  } st_t;

  // WAIT_RD of 0 behaves as 1
  localparam logic [15:0] WR_LAST =
    (WAIT_RD <= 1) ? 16'd0 : 16'(WAIT_RD - 1);
  localparam logic [15:0] WD_LAST =
    (WDOG <= 1) ? 16'd0 : 16'(WDOG - 1);

  st_t         st;
  st_t         st_nxt;
  logic [2:0]  fsm_r;
  logic [11:0] cnt_smp;
  logic [11:0] smp_inc;
  logic [15:0] tmr;
  logic [2:0]  cnt_stage;
  logic [2:0]  num_factors;
  logic [11:0] dftpts;
  logic        frame_err;
  logic        timeout;
  logic        sink_ready;
  logic        err_nxt;
  logic        tmo_nxt;
  logic        start;
  logic        stage_inc;
  logic        cfg_ok;
  logic        last_pass;
  logic        wd_hit;

  assign cfg_ok = (bus.cfg_nf >= 3'd1) &&
                  (bus.cfg_nf <= 3'd6) &&
                  (bus.cfg_dftpts != 12'd0);
  assign smp_inc   = cnt_smp + 12'd1;
  assign last_pass = (cnt_stage == num_factors - 3'd1);
  assign wd_hit    = (tmr >= WD_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      st    <= S_IDLE;
      fsm_r <= 3'd0;
    end else begin
      st    <= st_nxt;
      fsm_r <= st;
    end
  end

  always_comb begin
    st_nxt    = st;
    err_nxt   = 1'b0;
    tmo_nxt   = 1'b0;
    start     = 1'b0;
    stage_inc = 1'b0;
    unique case (st)
      S_IDLE: begin
        if (bus.in_valid && bus.in_sop) begin
          if (!cfg_ok) begin
            err_nxt = 1'b1;
          end else begin
            // the sop sample is sample 1 of the frame
            start = 1'b1;
            if (bus.in_eop) begin
              if (bus.cfg_dftpts == 12'd1)
                st_nxt = S_W2R;
              else
                err_nxt = 1'b1;
            end else if (bus.cfg_dftpts == 12'd1) begin
              err_nxt = 1'b1;
            end else begin
              st_nxt = S_SINK;
            end
          end
        end
      end
      S_SINK: begin
        if (bus.in_valid) begin
          if (bus.in_eop) begin
            if (smp_inc == dftpts) begin
              st_nxt = S_W2R;
            end else begin
              st_nxt  = S_IDLE;
              err_nxt = 1'b1;
            end
          end else if (smp_inc == dftpts) begin
            st_nxt  = S_IDLE;
            err_nxt = 1'b1;
          end
        end
      end
      S_W2R: begin
        if (tmr >= WR_LAST)
          st_nxt = S_RD;
      end
      S_RD: begin
        if (bus.rd_end) begin
          st_nxt = last_pass ? S_SRC : S_WWE;
        end else if (wd_hit) begin
          st_nxt  = S_IDLE;
          tmo_nxt = 1'b1;
        end
      end
      S_WWE: begin
        if (bus.wr_end) begin
          st_nxt    = S_W2R;
          stage_inc = 1'b1;
        end else if (wd_hit) begin
          st_nxt  = S_IDLE;
          tmo_nxt = 1'b1;
        end
      end
      S_SRC: begin
        if (bus.source_end) begin
          st_nxt = S_IDLE;
        end else if (wd_hit) begin
          st_nxt  = S_IDLE;
          tmo_nxt = 1'b1;
        end
      end
      default: st_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_smp     <= 12'd0;
      tmr         <= 16'd0;
      cnt_stage   <= 3'd0;
      num_factors <= 3'd0;
      dftpts      <= 12'd0;
      frame_err   <= 1'b0;
      timeout     <= 1'b0;
      sink_ready  <= 1'b1;
    end else begin
      frame_err  <= err_nxt;
      timeout    <= tmo_nxt;
      sink_ready <= (st_nxt == S_IDLE) ||
                    (st_nxt == S_SINK);
      if (start) begin
        dftpts      <= bus.cfg_dftpts;
        num_factors <= bus.cfg_nf;
        cnt_smp     <= 12'd1;
        cnt_stage   <= 3'd0;
      end else begin
        if (st == S_SINK && bus.in_valid)
          cnt_smp <= smp_inc;
        if (stage_inc)
          cnt_stage <= cnt_stage + 3'd1;
      end
      // one timer serves both the read turnaround and the watchdog
      if (st_nxt != st)
        tmr <= 16'd0;
      else if (st != S_IDLE && st != S_SINK)
        tmr <= tmr + 16'd1;
    end
  end

  assign bus.fsm         = st;
  assign bus.fsm_r       = fsm_r;
  assign bus.cnt_stage   = cnt_stage;
  assign bus.num_factors = num_factors;
  assign bus.dftpts      = dftpts;
  assign bus.frame_err   = frame_err;
  assign bus.timeout     = timeout;
  assign bus.sink_ready  = sink_ready;

endmodule
